// File: rtl/memory_cycle.sv
// memory_cycle: RISC-V MEM stage, req/ack data bus, load align/extend, MEM/WB register (optional MISALIGN_TRAP_EN)
module memory_cycle (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        MEM_stall_en,
  input  logic [31:0] MEM_alu_data,
  input  logic [31:0] MEM_rs2_data,
  input  logic [31:0] MEM_pc_four,
  input  logic [4:0]  MEM_rd_addr,
  input  logic        MEM_rd_wren,
  input  logic [8:0]  MEM_mem_en,
  input  logic [1:0]  MEM_wb_en,
  input  logic        MEM_ld_en,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        mem_busy_o,
  output logic [31:0] MEM_fwd_data,
  output logic [31:0] WB_alu_data,
  output logic [31:0] WB_ld_data,
  output logic [31:0] WB_pc_four,
  output logic [4:0]  WB_rd_addr,
  output logic        WB_rd_wren,
  output logic        WB_ld_en,
  output logic        WB_misalign_o,
  output logic [1:0]  WB_wb_en
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  state_t state, state_n;
  logic [31:0] ld_buf, ld_ext;
  logic [15:0] h16;
  logic [7:0]  b8;
  logic [2:0]  f3;
  logic [1:0]  a;
  logic        ld, st, acc, mis, cap, unused_mem_en;
  assign f3 = MEM_mem_en[2:0];
  assign a = MEM_alu_data[1:0];
  assign st = MEM_mem_en[4];
  assign ld = MEM_mem_en[3] & ~st;
  assign unused_mem_en = ^MEM_mem_en[8:5];
`ifdef MISALIGN_TRAP_EN
  logic half, word;
  assign half = st ? (f3 == 3'b001) : (f3[1:0] == 2'b01);
  assign word = st ? (f3[2:1] != 2'b00) : f3[1];
  assign mis = (ld | st) & ((half & a[0]) | (word & |a));
`else
  assign mis = 1'b0;
`endif
  assign acc = (ld | st) & ~mis;
  assign dmem_req_o = (state == S_WAIT);
  assign dmem_we_o = dmem_req_o & st;
  assign dmem_addr_o = {MEM_alu_data[31:2], 2'b00};
  assign dmem_wdata_o = f3 == 3'b000 ? {4{MEM_rs2_data[7:0]}} : f3 == 3'b001 ? {2{MEM_rs2_data[15:0]}} : MEM_rs2_data;
  assign dmem_be_o = f3 == 3'b000 ? 4'b0001 << a : f3 == 3'b001 ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
  assign mem_busy_o = (state == S_IDLE & acc) | dmem_req_o;
  assign MEM_fwd_data = MEM_alu_data;
  assign cap = MEM_stall_en & ~mem_busy_o;
  assign b8 = ld_buf[{a, 3'b000} +: 8];
  assign h16 = a[1] ? ld_buf[31:16] : ld_buf[15:0];
  assign ld_ext = f3[1] ? ld_buf : f3[0] ? {{16{~f3[2] & h16[15]}}, h16} : {{24{~f3[2] & b8[7]}}, b8};
  // state register; reset abandons any outstanding access
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_n;
  // next state: issue, wait for ack, then hold the result until MEM/WB takes it
  always_comb begin
    state_n = state == S_IDLE ? (acc ? S_WAIT : S_IDLE) :
              state == S_WAIT ? (dmem_ack_i ? S_DONE : S_WAIT) :
              (MEM_stall_en ? S_IDLE : S_DONE);
  end
  // read word buffer, only written by an ack while waiting
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) ld_buf <= '0;
    else if (state == S_WAIT && dmem_ack_i) ld_buf <= dmem_rdata_i;
  // MEM/WB pipeline register
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      WB_alu_data <= '0;
      WB_ld_data  <= '0;
      WB_pc_four  <= '0;
      WB_rd_addr  <= '0;
      WB_rd_wren  <= 1'b0;
      WB_ld_en    <= 1'b0;
      WB_wb_en    <= '0;
    end else if (cap) begin
      WB_alu_data <= MEM_alu_data;
      WB_ld_data  <= ld_ext;
      WB_pc_four  <= MEM_pc_four;
      WB_rd_addr  <= MEM_rd_addr;
      WB_rd_wren  <= MEM_rd_wren & ~mis;
      WB_ld_en    <= MEM_ld_en;
      WB_wb_en    <= MEM_wb_en;
    end
`ifdef MISALIGN_TRAP_EN
  // trap flag travels with the trapped operation
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) WB_misalign_o <= 1'b0;
    else if (cap) WB_misalign_o <= mis;
`else
  assign WB_misalign_o = 1'b0;
`endif
endmodule

// File: tb/tb_memory_cycle.sv
// tb_memory_cycle: scoreboard bench for memory_cycle (bus and MEM/WB monitors)
module tb_memory_cycle;
  logic clk_i = 0, rst_n = 0, MEM_stall_en = 0, MEM_rd_wren = 0, MEM_ld_en = 0, dmem_ack_i = 0;
  logic [31:0] MEM_alu_data = 0, MEM_rs2_data = 0, MEM_pc_four = 0, dmem_rdata_i = 0;
  logic [4:0] MEM_rd_addr = 0;
  logic [8:0] MEM_mem_en = 0;
  logic [1:0] MEM_wb_en = 0;
  logic dmem_req_o, dmem_we_o, mem_busy_o, WB_rd_wren, WB_ld_en, WB_misalign_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, MEM_fwd_data, WB_alu_data, WB_ld_data, WB_pc_four;
  logic [3:0] dmem_be_o;
  logic [4:0] WB_rd_addr;
  logic [1:0] WB_wb_en;

  memory_cycle dut (
    .clk_i(clk_i), .rst_n(rst_n), .MEM_stall_en(MEM_stall_en), .MEM_alu_data(MEM_alu_data),
    .MEM_rs2_data(MEM_rs2_data), .MEM_pc_four(MEM_pc_four), .MEM_rd_addr(MEM_rd_addr),
    .MEM_rd_wren(MEM_rd_wren), .MEM_mem_en(MEM_mem_en), .MEM_wb_en(MEM_wb_en), .MEM_ld_en(MEM_ld_en),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_be_o(dmem_be_o), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i), .mem_busy_o(mem_busy_o),
    .MEM_fwd_data(MEM_fwd_data), .WB_alu_data(WB_alu_data), .WB_ld_data(WB_ld_data), .WB_pc_four(WB_pc_four),
    .WB_rd_addr(WB_rd_addr), .WB_rd_wren(WB_rd_wren), .WB_ld_en(WB_ld_en), .WB_misalign_o(WB_misalign_o),
    .WB_wb_en(WB_wb_en)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {logic [31:0] alu, ld, pc; logic [4:0] rd; logic wren, ldn, mis; logic [1:0] wb;} wb_t;
  typedef struct {logic we; logic [31:0] addr, wdata; logic [3:0] be;} bus_t;
  wb_t wbq[$];
  bus_t busq[$];
  wb_t wb_e;
  bus_t bus_e;
  int checks = 0, failures = 0, k_op = 0;
  logic [31:0] last_alu = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(posedge clk_i)
    if (dmem_req_o && dmem_ack_i) begin
      if (busq.size() == 0) chk("bus_unexpected", 1, 0);
      else begin
        bus_e = busq.pop_front();
        chk("bus_we", dmem_we_o, bus_e.we);
        chk("bus_addr", dmem_addr_o, bus_e.addr);
        chk("bus_be", dmem_be_o, bus_e.be);
        if (bus_e.we) chk("bus_wdata", dmem_wdata_o, bus_e.wdata);
      end
    end

  always @(posedge clk_i)
    if (rst_n && MEM_stall_en && !mem_busy_o) begin
      #1;
      if (wbq.size() == 0) chk("wb_unexpected", 1, 0);
      else begin
        wb_e = wbq.pop_front();
        chk("wb_alu", WB_alu_data, wb_e.alu);
        chk("wb_ld", WB_ld_data, wb_e.ld);
        chk("wb_pc", WB_pc_four, wb_e.pc);
        chk("wb_rd", WB_rd_addr, wb_e.rd);
        chk("wb_wren", WB_rd_wren, wb_e.wren);
        chk("wb_lden", WB_ld_en, wb_e.ldn);
        chk("wb_mis", WB_misalign_o, wb_e.mis);
        chk("wb_wben", WB_wb_en, wb_e.wb);
      end
    end

  task automatic run(input logic [31:0] alu, input logic [31:0] rs2, input logic [8:0] me,
                     input logic [31:0] rword, input int nw, input int hold, input logic [31:0] eld,
                     input logic emis, input int ereq, input int ebusy, input logic [3:0] ebe,
                     input logic [31:0] ewd);
    int nreq, nbusy;
    bit done;
    logic st;
    st = me[4];
    @(negedge clk_i);
    k_op++;
    MEM_alu_data = alu; MEM_rs2_data = rs2; MEM_mem_en = me;
    MEM_pc_four = 32'h1000 + k_op * 4; MEM_rd_addr = k_op[4:0]; MEM_rd_wren = ~st;
    MEM_wb_en = k_op[1:0]; MEM_ld_en = me[3] & ~st;
    wbq.push_back('{alu, eld, MEM_pc_four, MEM_rd_addr, ~st & ~emis, MEM_ld_en, emis, MEM_wb_en});
    if (ereq > 0) busq.push_back('{st, {alu[31:2], 2'b00}, ewd, ebe});
    nreq = 0; nbusy = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      MEM_stall_en = (c >= hold);
      #1;
      if (dmem_req_o) begin
        if (nreq == nw) begin dmem_ack_i = 1; dmem_rdata_i = rword; end
        nreq++;
      end
      if (mem_busy_o) nbusy++;
      else if (MEM_stall_en) done = 1;
      if (c < hold) chk("hold_wb_alu", WB_alu_data, last_alu);
      if (!done) begin @(negedge clk_i); dmem_ack_i = 0; end
    end
    if (!done) chk("op_timeout", 0, 1);
    chk("req_cycles", nreq, ereq);
    chk("busy_cycles", nbusy, ebusy);
    @(posedge clk_i);
    #1;
    MEM_stall_en = 0; MEM_mem_en = 0;
    last_alu = alu;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk_i);
    chk("reset_req", {dmem_req_o, mem_busy_o}, 0);
    chk("reset_wb", {WB_alu_data, WB_ld_data}, 0);
    chk("reset_wb2", {WB_pc_four, WB_rd_addr, WB_rd_wren, WB_ld_en, WB_misalign_o, WB_wb_en}, 0);
    rst_n = 1;
    run(32'h100, 32'hDEADBEEF, 9'h012, 32'h0, 2, 0, 32'h0, 0, 3, 4, 4'hF, 32'hDEADBEEF);
    run(32'h103, 32'h0, 9'h008, 32'h80123456, 0, 0, 32'hFFFFFF80, 0, 1, 2, 4'h8, 32'h0);
    run(32'h102, 32'h0, 9'h00D, 32'hBEEF1234, 1, 0, 32'h0000BEEF, 0, 2, 3, 4'hF, 32'h0);
    run(32'h101, 32'h000000AB, 9'h010, 32'h11223344, 0, 0, 32'h00000033, 0, 1, 2, 4'h2, 32'hABABABAB);
    run(32'h102, 32'h0000CAFE, 9'h011, 32'h80017FFF, 0, 0, 32'hFFFF8001, 0, 1, 2, 4'hC, 32'hCAFECAFE);
    run(32'h55, 32'h12345678, 9'h1E0, 32'h0, 0, 2, 32'h0000007F, 0, 0, 0, 4'h0, 32'h0);
    run(32'h100, 32'h0, 9'h009, 32'h00008000, 0, 0, 32'hFFFF8000, 0, 1, 2, 4'h3, 32'h0);
`ifdef MISALIGN_TRAP_EN
    run(32'h101, 32'h0, 9'h00A, 32'hCAFEF00D, 0, 0, 32'h00008000, 1, 0, 0, 4'h0, 32'h0);
`else
    run(32'h101, 32'h0, 9'h00A, 32'hCAFEF00D, 0, 0, 32'hCAFEF00D, 0, 1, 2, 4'hF, 32'h0);
`endif
    @(negedge clk_i);
    MEM_alu_data = 32'h200; MEM_mem_en = 9'h00A; MEM_stall_en = 1;
    @(negedge clk_i);
    #1 chk("rst_pre_req", dmem_req_o, 1);
    rst_n = 0;
    #1 chk("rst_req_drop", dmem_req_o, 0);
    chk("rst_wb", {WB_alu_data, WB_ld_data}, 0);
    chk("rst_wb2", {WB_pc_four, WB_rd_addr, WB_rd_wren, WB_ld_en, WB_misalign_o, WB_wb_en}, 0);
    MEM_mem_en = 0; MEM_stall_en = 0;
    @(negedge clk_i) rst_n = 1;
    @(negedge clk_i);
    dmem_ack_i = 1; dmem_rdata_i = 32'hFFFFFFFF;
    #1 chk("late_ack_req", dmem_req_o, 0);
    @(negedge clk_i);
    dmem_ack_i = 0;
    #1 chk("late_ack_idle", {dmem_req_o, mem_busy_o}, 0);
    last_alu = 0;
    run(32'h77, 32'h0, 9'h002, 32'h0, 0, 0, 32'h0, 0, 0, 0, 4'h0, 32'h0);
    run(32'h100, 32'h0, 9'h00C, 32'h123456F0, 3, 0, 32'h000000F0, 0, 4, 5, 4'hF, 32'h0);
    run(32'h104, 32'h0BADF00D, 9'h01A, 32'h0, 0, 0, 32'h0, 0, 1, 2, 4'hF, 32'h0BADF00D);
    repeat (2) @(negedge clk_i);
    chk("wbq_drained", wbq.size(), 0);
    chk("busq_drained", busq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/memory_cycle.md
# memory_cycle

Pipeline MEM stage of the RISC-V core, directly downstream of the execute stage. It consumes the EX/MEM register outputs and issues loads and stores to data memory over a req/ack handshake. Load data is aligned and sign- or zero-extended here, and the stage holds the upstream pipeline while a bus access is outstanding. Results are registered into the MEM/WB pipeline register.

## Interface
Parameters: none.

Clock and reset (already decided): reset `rst_n`, asynchronous, active-low; clock `clk_i`.

Ports:
- clk_i  in  1  pipeline clock
- rst_n  in  1  async active-low reset
- MEM_stall_en  in  1  1 = MEM/WB register captures, 0 = hold
- MEM_alu_data  in  32  ALU result, also the effective address
- MEM_rs2_data  in  32  store data
- MEM_pc_four  in  32  PC+4 for the link write
- MEM_rd_addr  in  5  destination register
- MEM_rd_wren  in  1  register-file write enable
- MEM_mem_en  in  9  [2:0] funct3 size/sign, [3] load, [4] store, [8:5] ignored
- MEM_wb_en  in  2  writeback select, passed through
- MEM_ld_en  in  1  load marker for the forwarding unit, passed through
- dmem_req_o  out  1  bus request
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  32  word address {MEM_alu_data[31:2], 2'b00}
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_be_o  out  4  byte enables
- dmem_ack_i  in  1  access complete; rdata valid in this cycle
- dmem_rdata_i  in  32  read word
- mem_busy_o  out  1  hazard-unit stall request, combinational
- MEM_fwd_data  out  32  combinational copy of MEM_alu_data, used for forwarding
- WB_alu_data, WB_ld_data, WB_pc_four  out  32  registered results
- WB_rd_addr  out  5
- WB_rd_wren, WB_ld_en, WB_misalign_o  out  1
- WB_wb_en  out  2

## Operation
- An access is when load or store is set. If both are set, the access is treated as a store.
- FSM states are S_IDLE, S_WAIT and S_DONE.
  - S_IDLE with an access: go to S_WAIT.
  - S_IDLE with no access: stay in S_IDLE.
  - S_WAIT: stay until dmem_ack_i = 1. On ack, latch dmem_rdata_i into ld_buf and go to S_DONE.
  - S_DONE: if MEM_stall_en = 1, go to S_IDLE; otherwise stay in S_DONE. No re-issue occurs while in S_DONE.
- dmem_req_o = (state == S_WAIT). dmem_we_o = store, qualified by req.
- mem_busy_o = (S_IDLE & access) | S_WAIT.
- Store lanes:
  - SB: wdata = {4{rs2[7:0]}}, be = 4'b0001 << addr[1:0].
  - SH: wdata = {2{rs2[15:0]}}, be = 4'b0011 << {addr[1], 1'b0}.
  - SW and any other funct3: wdata = rs2, be = 4'b1111.
- Load extract from ld_buf:
  - Byte lane is selected by addr[1:0]; halfword lane by addr[1].
  - funct3[2] = 1 zero-extends; funct3[2] = 0 sign-extends.
  - funct3 011, 110 and 111 are treated as LW.
- MEM/WB register capture:
  - Captures when MEM_stall_en & ~mem_busy_o; otherwise holds.
  - Captures the extended load into WB_ld_data and passes the other fields through.

## Timing
- Reset value of every registered output and ld_buf is 0. State resets to S_IDLE.
- Reset mid-access: state goes to S_IDLE and dmem_req_o drops immediately (asynchronously). The access is abandoned.
- Non-memory operation: 1 cycle in MEM, mem_busy_o = 0.
- Access with ack in its first S_WAIT cycle: 3 cycles (S_IDLE, S_WAIT, S_DONE). Each extra wait cycle adds 1 cycle.
- dmem_addr_o, dmem_wdata_o and dmem_be_o are stable for the whole time req is high, because upstream is stalled.
- An ack arriving outside S_WAIT is ignored.

## Configuration
- Macro: `MISALIGN_TRAP_EN`.
- Misaligned means: halfword with addr[0] = 1, or word with addr[1:0] != 0.
- Defined:
  - A misaligned access skips the bus and behaves as a 1-cycle non-memory operation.
  - WB_misalign_o = 1 and WB_rd_wren = 0 for that operation.
- Undefined:
  - The access proceeds on the bus with the lane rules above.
  - WB_misalign_o is tied to 0.

## Test plan
- SW at 0x100 with data 0xDEADBEEF, ack after 2 wait cycles -> req high for 3 cycles, be = 1111, wdata = 0xDEADBEEF, mem_busy_o high for 4 cycles.
- LB at 0x103 with rdata 0x80123456, ack immediate -> WB_ld_data = 0xFFFFFF80, captured in the S_DONE cycle.
- LHU at 0x102 with rdata 0xBEEF1234 -> WB_ld_data = 0x0000BEEF. SB at 0x101 with rs2 = 0xAB -> be = 0010, wdata = 0xABABABAB.
- ADD result 0x55 with MEM_stall_en held at 0 for 2 cycles -> no req, WB outputs unchanged; on release, WB_alu_data = 0x55.
- rst_n pulsed low in S_WAIT -> req drops the same cycle, all WB outputs 0. A later ack is ignored.
- LW at 0x101: with `MISALIGN_TRAP_EN` -> no req, WB_misalign_o = 1, WB_rd_wren = 0. Without it -> req to 0x100, be = 1111.
